// File: rtl/ccff_cfg_pkg.sv
// Shared definitions for the configuration-chain loader: FSM states and default geometry.
package ccff_cfg_pkg;

  localparam int unsigned CHAIN_LEN_DEF = 40;
  localparam int unsigned WORD_W_DEF    = 8;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SHIFT,
    FINISH
  } state_e;

endpackage

// File: rtl/ccff_shifter.sv
// Word-wide shift register with a total-bit counter and a bit-in-word index.
// Reports the last chain bit and the last bit of the current word to the controller.
module ccff_shifter #(
  parameter int unsigned CHAIN_LEN = 40,
  parameter int unsigned WORD_W    = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              load_i,
  input  logic [WORD_W-1:0] data_i,
  input  logic              shift_i,
  output logic              head_o,
  output logic              last_bit_o,
  output logic              word_last_o
);

  localparam int unsigned CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int unsigned IDX_W = $clog2(WORD_W + 1);

  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic [IDX_W-1:0]  idx_q,   idx_d;

  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    if (clr_i) begin
      cnt_d = '0;
    end
    if (load_i) begin
      shreg_d = data_i;
      idx_d   = '0;
    end else if (shift_i) begin
      shreg_d = shreg_q >> 1;
      cnt_d   = cnt_q + CNT_W'(1);
      idx_d   = idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shreg_q <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  assign head_o      = shreg_q[0];
  assign last_bit_o  = (cnt_q == CNT_W'(CHAIN_LEN - 1));
  assign word_last_o = (idx_q == IDX_W'(WORD_W - 1));

endmodule

// File: rtl/ccff_chain_loader.sv
// Streams bitstream words LSB-first into a configuration flip-flop chain of CHAIN_LEN bits,
// with start/abort control and sticky done/aborted status.
module ccff_chain_loader
  import ccff_cfg_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = CHAIN_LEN_DEF,
  parameter int unsigned WORD_W    = WORD_W_DEF
) (
  input  logic              prog_clk,
  input  logic              pReset_n,
  input  logic              cfg_start,
  input  logic              cfg_abort,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              ccff_en,
  output logic              busy,
  output logic              done,
  output logic              aborted
);

  state_e state_q, state_d;
  logic   done_q, done_d;
  logic   aborted_q, aborted_d;
  logic   sh_clr, sh_load, sh_shift;
  logic   sh_head, sh_last_bit, sh_word_last;

  ccff_shifter #(
    .CHAIN_LEN (CHAIN_LEN),
    .WORD_W    (WORD_W)
  ) u_shifter (
    .clk_i       (prog_clk),
    .rst_ni      (pReset_n),
    .clr_i       (sh_clr),
    .load_i      (sh_load),
    .data_i      (cfg_data),
    .shift_i     (sh_shift),
    .head_o      (sh_head),
    .last_bit_o  (sh_last_bit),
    .word_last_o (sh_word_last)
  );

  always_comb begin
    state_d   = state_q;
    done_d    = done_q;
    aborted_d = aborted_q;
    sh_clr    = 1'b0;
    sh_load   = 1'b0;
    sh_shift  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // start wins over a simultaneous abort here
        if (cfg_start) begin
          sh_clr    = 1'b1;
          done_d    = 1'b0;
          aborted_d = 1'b0;
          state_d   = FETCH;
        end
      end
      FETCH: begin
        if (cfg_abort) begin
          aborted_d = 1'b1;
          done_d    = 1'b0;
          state_d   = IDLE;
        end else if (cfg_valid) begin
          sh_load = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // The bit on ccff_head is captured by the chain this cycle even when aborting.
        sh_shift = 1'b1;
        if (cfg_abort) begin
          aborted_d = 1'b1;
          done_d    = 1'b0;
          state_d   = IDLE;
        end else if (sh_last_bit) begin
          done_d  = 1'b1;
          state_d = FINISH;
        end else if (sh_word_last) begin
          state_d = FETCH;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      state_q   <= IDLE;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  assign cfg_ready = (state_q == FETCH);
  assign ccff_en   = (state_q == SHIFT);
  assign ccff_head = ccff_en & sh_head;
  assign busy      = (state_q == FETCH) || (state_q == SHIFT);
  assign done      = done_q;
  assign aborted   = aborted_q;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Randomized bench for ccff_chain_loader: a 40-bit and a 12-bit instance, each checked against
// the bit stream expected from the words offered, plus latency and status rules.
module tb_ccff_chain_loader;

  localparam int W = 8;

  logic         prog_clk = 1'b0;
  logic         pReset_n;
  logic         cfg_start [2];
  logic         cfg_abort [2];
  logic         cfg_valid [2];
  logic [W-1:0] cfg_data  [2];
  logic         cfg_ready [2];
  logic         ccff_head [2];
  logic         ccff_en   [2];
  logic         busy      [2];
  logic         done      [2];
  logic         aborted   [2];

  int           n_checks = 0;
  int           n_errors = 0;
  logic [W-1:0] wbuf [8];

  always #5 prog_clk = ~prog_clk;

  ccff_chain_loader #(.CHAIN_LEN(40), .WORD_W(W)) u_dut40 (
    .prog_clk (prog_clk),     .pReset_n  (pReset_n),
    .cfg_start(cfg_start[0]), .cfg_abort (cfg_abort[0]),
    .cfg_data (cfg_data[0]),  .cfg_valid (cfg_valid[0]),
    .cfg_ready(cfg_ready[0]), .ccff_head (ccff_head[0]),
    .ccff_en  (ccff_en[0]),   .busy      (busy[0]),
    .done     (done[0]),      .aborted   (aborted[0])
  );

  ccff_chain_loader #(.CHAIN_LEN(12), .WORD_W(W)) u_dut12 (
    .prog_clk (prog_clk),     .pReset_n  (pReset_n),
    .cfg_start(cfg_start[1]), .cfg_abort (cfg_abort[1]),
    .cfg_data (cfg_data[1]),  .cfg_valid (cfg_valid[1]),
    .cfg_ready(cfg_ready[1]), .ccff_head (ccff_head[1]),
    .ccff_en  (ccff_en[1]),   .busy      (busy[1]),
    .done     (done[1]),      .aborted   (aborted[1])
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected chain stream: first n bits of the offered words, each word LSB first.
  function automatic logic [63:0] ref_stream(input int n);
    logic [63:0] v = '0;
    for (int k = 0; k < n; k++)
      v[k] = wbuf[k / W][k % W];
    return v;
  endfunction

  always @(negedge prog_clk) begin
    if (pReset_n === 1'b1) begin
      for (int i = 0; i < 2; i++) begin
        chk("head_quiet", 64'(ccff_head[i] & ~ccff_en[i]), 64'd0);
        chk("ready_vs_en", 64'(cfg_ready[i] & ccff_en[i]), 64'd0);
      end
    end
  end

  task automatic idle_inputs();
    for (int i = 0; i < 2; i++) begin
      cfg_start[i] = 1'b0;
      cfg_abort[i] = 1'b0;
      cfg_valid[i] = 1'b0;
      cfg_data[i]  = '0;
    end
  endtask

  // One load on instance d of chain length L. gap_word/gap_len hold valid low while FETCH waits
  // for that word; abort_at/spur_at/rst_at act on the cycle carrying that shift number (0 = off).
  task automatic run_load(input int d, input int L, input int navail,
                          input int gap_word, input int gap_len,
                          input int abort_at, input int spur_at, input int rst_at,
                          output logic [63:0] got_vec);
    int cyc = 0, nsh = 0, widx = 0, gap_rem = gap_len;
    bit fin = 1'b0;
    int nwords = (L + W - 1) / W;
    got_vec = '0;
    @(negedge prog_clk);
    cfg_start[d] = 1'b1;
    while (!fin && cyc < 2000) begin
      @(negedge prog_clk);
      cyc++;
      cfg_start[d] = 1'b0;
      cfg_abort[d] = 1'b0;
      if (ccff_en[d]) begin
        got_vec[nsh] = ccff_head[d];
        nsh++;
      end
      if (cyc == 1)
        chk("busy_after_start", {busy[d], cfg_ready[d]}, 2'b11);
      if (done[d]) begin
        fin = 1'b1;
        cfg_valid[d] = 1'b0;
        chk("done_latency", cyc, 1 + nwords + L + gap_len);
        chk("shift_count", nsh, L);
        chk("chain_bits", got_vec, ref_stream(L));
        chk("words_accepted", widx, nwords);
        chk("finish_status", {busy[d], aborted[d], ccff_en[d]}, 3'b000);
        @(negedge prog_clk);
        chk("done_sticky", {done[d], busy[d], cfg_ready[d]}, 3'b100);
      end else if (aborted[d]) begin
        fin = 1'b1;
        cfg_valid[d] = 1'b0;
        chk("abort_status", {ccff_en[d], busy[d], done[d]}, 3'b000);
        chk("abort_shift_count", nsh, abort_at);
        chk("abort_partial_bits", got_vec, ref_stream(abort_at));
        @(negedge prog_clk);
        chk("aborted_sticky", {aborted[d], busy[d], ccff_en[d]}, 3'b100);
      end else if (rst_at != 0 && ccff_en[d] && nsh == rst_at) begin
        fin = 1'b1;
        idle_inputs();
        pReset_n = 1'b0;
        #1;
        chk("async_reset_outputs",
            {ccff_en[d], ccff_head[d], cfg_ready[d], busy[d], done[d], aborted[d]}, 6'd0);
        @(negedge prog_clk);
        pReset_n = 1'b1;
        @(negedge prog_clk);
        @(negedge prog_clk);
        chk("idle_after_reset", {cfg_ready[d], busy[d], ccff_en[d], done[d]}, 4'd0);
      end else begin
        if (spur_at != 0 && ccff_en[d] && nsh == spur_at)
          cfg_start[d] = 1'b1;
        if (abort_at != 0 && ccff_en[d] && nsh == abort_at)
          cfg_abort[d] = 1'b1;
        if (cfg_ready[d] && widx == gap_word && gap_rem > 0) begin
          cfg_valid[d] = 1'b0;
          gap_rem--;
          chk("gap_no_shift", ccff_en[d], 1'b0);
        end else begin
          cfg_valid[d] = (widx < navail);
        end
        cfg_data[d] = wbuf[widx < 8 ? widx : 7];
        if (cfg_valid[d] && cfg_ready[d] && !cfg_abort[d])
          widx++;
      end
    end
    if (!fin)
      chk("timeout", 1'b0, 1'b1);
    idle_inputs();
    repeat (2) @(negedge prog_clk);
  endtask

  task automatic rand_words();
    for (int i = 0; i < 8; i++)
      wbuf[i] = W'($urandom);
  endtask

  logic [63:0] v_a, v_b;

  initial begin
    idle_inputs();
    pReset_n = 1'b0;
    repeat (3) @(negedge prog_clk);
    for (int i = 0; i < 2; i++)
      chk("reset_outputs", {cfg_ready[i], ccff_head[i], ccff_en[i], busy[i], done[i], aborted[i]},
          6'd0);
    pReset_n = 1'b1;
    repeat (3) @(negedge prog_clk);
    chk("idle_no_start", {cfg_ready[0], busy[0], cfg_ready[1], busy[1]}, 4'd0);

    for (int i = 0; i < 8; i++) wbuf[i] = W'(i + 1);
    run_load(0, 40, 6, -1, 0, 0, 0, 0, v_a);

    rand_words();
    wbuf[0] = 8'hFF;
    wbuf[1] = 8'hA5;
    run_load(1, 12, 3, -1, 0, 0, 0, 0, v_a);

    rand_words();
    run_load(0, 40, 5, -1, 0, 0, 0, 0, v_a);
    run_load(0, 40, 5, 2, 10, 0, 0, 0, v_b);
    chk("gap_same_chain", v_b, v_a);

    rand_words();
    run_load(0, 40, 5, -1, 0, 17, 0, 0, v_a);
    rand_words();
    run_load(0, 40, 5, -1, 0, 0, 0, 0, v_a);

    rand_words();
    run_load(0, 40, 5, -1, 0, 0, 20, 0, v_a);

    rand_words();
    run_load(0, 40, 5, -1, 0, 0, 0, 10, v_a);
    chk("no_status_after_reset", {done[0], aborted[0]}, 2'b00);
    rand_words();
    run_load(0, 40, 5, -1, 0, 0, 0, 0, v_a);

    for (int r = 0; r < 4; r++) begin
      rand_words();
      run_load(0, 40, 5 + int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
               int'($urandom_range(0, 6)), 0, 0, 0, v_a);
      rand_words();
      run_load(1, 12, 2 + int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
               int'($urandom_range(0, 6)), 0, 0, 0, v_a);
    end
    rand_words();
    run_load(1, 12, 4, -1, 0, int'($urandom_range(1, 11)), 0, 0, v_a);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ccff_chain_loader.md
CCFF_CHAIN_LOADER -- requirements
Module: ccff_chain_loader

Interface
REQ-001 SHALL have parameter: CHAIN_LEN, 40, number of configuration flip-flops in the downstream chain (≥1).
REQ-002 SHALL have parameter: WORD_W, 8, width of each bitstream word (≥1).
REQ-003 SHALL have port: prog_clk  input  1  single clock for all state.
REQ-004 SHALL have port: pReset_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port: cfg_start  input  1  one-cycle pulse that begins a load.
REQ-006 SHALL have port: cfg_abort  input  1  terminates the load in progress.
REQ-007 SHALL have port: cfg_data  input  WORD_W  bitstream word, LSB shifted first.
REQ-008 SHALL have port: cfg_valid  input  1  cfg_data is valid.
REQ-009 SHALL have port: cfg_ready  output  1  loader accepts a word this cycle.
REQ-010 SHALL have port: ccff_head  output  1  serial bit to the chain head.
REQ-011 SHALL have port: ccff_en  output  1  chain shift enable; the chain captures ccff_head on each prog_clk edge where ccff_en=1.
REQ-012 SHALL have port: busy  output  1  load in progress.
REQ-013 SHALL have port: done  output  1  sticky: last load completed with all CHAIN_LEN bits shifted.
REQ-014 SHALL have port: aborted  output  1  sticky: last load ended by cfg_abort.

Function
REQ-015 SHALL implement FSM states IDLE, FETCH, SHIFT, FINISH.
REQ-016 IDLE: on cfg_start=1, SHALL clear done/aborted and the bit counter, assert busy, and go to FETCH the next cycle.
REQ-017 FETCH: cfg_ready SHALL be 1; a word SHALL be accepted only on cfg_valid&&cfg_ready; on accept, SHALL latch it into the shift register and go to SHIFT.
REQ-018 cfg_ready SHALL be 0 in every state except FETCH, so at most one word is accepted per FETCH visit.
REQ-019 SHIFT: each cycle SHALL drive ccff_head=shreg[0] and ccff_en=1, right-shift shreg, and increment the bit counter.
REQ-020 SHALL shift exactly CHAIN_LEN bits in total; counter width SHALL be $clog2(CHAIN_LEN+1).
REQ-021 After the WORD_W-th bit of a word, SHALL go to FETCH if counter<CHAIN_LEN, otherwise FINISH.
REQ-022 When counter reaches CHAIN_LEN mid-word, SHALL stop shifting immediately, go to FINISH, and discard the remaining bits of that word.
REQ-023 FINISH: SHALL set done=1 and busy=0 for one cycle, then go to IDLE.
REQ-024 ccff_en SHALL be 0 outside SHIFT; ccff_head SHALL be 0 when ccff_en=0.
REQ-025 Load throughput: WORD_W shift cycles plus 1 FETCH cycle per word when cfg_valid is held high.
REQ-026 cfg_valid low in FETCH SHALL stall the load with ccff_en=0 and no timeout.
REQ-027 cfg_abort=1 in FETCH or SHIFT SHALL go to IDLE next cycle with ccff_en=0, busy=0, aborted=1, done=0; the partially shifted chain is left as is.
REQ-028 cfg_abort SHALL take priority over a simultaneous word accept or final shift.
REQ-029 cfg_start while busy SHALL be ignored.
REQ-030 cfg_start and cfg_abort both high in IDLE SHALL be treated as start only.

Reset
REQ-031 pReset_n=0 SHALL asynchronously force state=IDLE, counter=0, shreg=0, cfg_ready=0, ccff_en=0, ccff_head=0, busy=0, done=0, aborted=0.
REQ-032 Reset asserted mid-load SHALL leave done=0 and aborted=0; the partial chain contents are not a specified value.
REQ-033 Release of reset SHALL be synchronised externally; the block SHALL leave IDLE only on cfg_start.

Structure
REQ-034 FSM state enum and the default CHAIN_LEN/WORD_W constants SHALL live in the shared package ccff_cfg_pkg.
REQ-035 The shift register plus bit counter SHALL be one sub-module, ccff_shifter; the FSM SHALL stay in the top level.

Verification
REQ-036 CHAIN_LEN=40, WORD_W=8, start, then 5 words 0x01..0x05 with valid held -> 40 ccff_en pulses, head sequence equals LSB-first concatenation, done=1 at cycle 46 after start.
REQ-037 CHAIN_LEN=12, WORD_W=8, words 0xFF,0xA5 -> 12 shifts, bits 4..7 of 0xA5 never driven, done=1, only 2 words accepted.
REQ-038 valid deasserted for 10 cycles between words -> ccff_en=0 throughout the gap, final chain contents identical to the no-gap case.
REQ-039 cfg_abort during shift 17 of 40 -> ccff_en=0 the next cycle, aborted=1, done=0, busy=0; a new start reloads all 40 bits cleanly.
REQ-040 pReset_n pulled low during SHIFT -> all outputs 0 in the same cycle (asynchronous), FSM in IDLE.
REQ-041 cfg_start pulsed during SHIFT -> ignored, counter unaffected, single done at the end.
